// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller port bundle: register indices/stall sources in, pipeline enables/flushes/forward selects out.
// master = pipeline datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic [4:0]       wb_rd;
  logic             mem_regwrite;
  logic             wb_regwrite;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread,
           mem_rd, wb_rd, mem_regwrite, wb_regwrite, branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, fwd_a, fwd_b, state,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread,
           mem_rd, wb_rd, mem_regwrite, wb_regwrite, branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, fwd_a, fwd_b, state,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use bubbles, branch squash, data-memory wait with timeout, EX forwarding.
// Control outputs are combinational from state/inputs (0 cycles); a pending memory access freezes PC/IF/ID/EX.
module pipe_hazard_ctrl #(
  parameter int BR_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_t;

  localparam logic [3:0]  BR_INIT = 4'(BR_BUBBLES - 1);
  localparam logic [15:0] TMO     = 16'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [3:0]       flush_q, flush_d;
  logic [15:0]      wait_q, wait_d;
  logic             tmo_q, tmo_set;
  logic [CNT_W-1:0] stall_q;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic memstall, loaduse, run_eval;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mrw, input logic [4:0] mrd,
                                         input logic wrw, input logic [4:0] wrd);
    if (mrw && mrd != 5'd0 && mrd == rs)      fwd_sel = 2'b10;
    else if (wrw && wrd != 5'd0 && wrd == rs) fwd_sel = 2'b01;
    else                                      fwd_sel = 2'b00;
  endfunction

  assign memstall = hz.mem_req & ~hz.mem_ready;
  assign loaduse  = hz.ex_memread & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs1 & (hz.ex_rd == hz.id_rs1)) |
                     (hz.id_use_rs2 & (hz.ex_rd == hz.id_rs2)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    state_d    = state_q;
    flush_d    = flush_q;
    wait_d     = wait_q;
    tmo_set    = 1'b0;
    run_eval   = 1'b0;

    // Outputs are pinned to their idle values while reset is asserted.
    if (rst_n) begin
      fwd_a = fwd_sel(hz.ex_rs1, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
      fwd_b = fwd_sel(hz.ex_rs2, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);

      case (state_q)
        MEM_WAIT: begin
          if (memstall) begin
            if (wait_q >= TMO) begin
              tmo_set = 1'b1;
              state_d = RUN;
            end else begin
              pc_en   = 1'b0;
              ifid_en = 1'b0;
              idex_en = 1'b0;
              wait_d  = wait_q + 16'd1;
            end
          end else begin
            run_eval = 1'b1;
          end
        end
        FLUSH: begin
          if (memstall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
          end else begin
            ifid_flush = 1'b1;
            flush_d    = flush_q - 4'd1;
            if (flush_q <= 4'd1) state_d = RUN;
          end
        end
        default: begin
          if (memstall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            state_d = MEM_WAIT;
            wait_d  = 16'd1;
          end else begin
            run_eval = 1'b1;
          end
        end
      endcase

      // A completed memory access resolves branches/load-use in the same cycle.
      if (run_eval) begin
        state_d = RUN;
        if (hz.branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (BR_BUBBLES > 1) begin
            state_d = FLUSH;
            flush_d = BR_INIT;
          end
        end else if (loaduse) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flush_q <= 4'd0;
      wait_q  <= 16'd0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      if (tmo_set) tmo_q <= 1'b1;
      if (!pc_en && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_flush   = idex_flush;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.state        = state_q;
  assign hz.mem_timeout  = tmo_q;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a has BR_BUBBLES=3 / MEM_TIMEOUT=255, dut_b has BR_BUBBLES=1 / MEM_TIMEOUT=3, same stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifc_a ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) ifc_b ();

  pipe_hazard_ctrl #(.BR_BUBBLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(ifc_a)
  );
  pipe_hazard_ctrl #(.BR_BUBBLES(1), .MEM_TIMEOUT(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(ifc_b)
  );

  assign ifc_b.id_rs1       = ifc_a.id_rs1;
  assign ifc_b.id_rs2       = ifc_a.id_rs2;
  assign ifc_b.id_use_rs1   = ifc_a.id_use_rs1;
  assign ifc_b.id_use_rs2   = ifc_a.id_use_rs2;
  assign ifc_b.ex_rs1       = ifc_a.ex_rs1;
  assign ifc_b.ex_rs2       = ifc_a.ex_rs2;
  assign ifc_b.ex_rd        = ifc_a.ex_rd;
  assign ifc_b.ex_memread   = ifc_a.ex_memread;
  assign ifc_b.mem_rd       = ifc_a.mem_rd;
  assign ifc_b.wb_rd        = ifc_a.wb_rd;
  assign ifc_b.mem_regwrite = ifc_a.mem_regwrite;
  assign ifc_b.wb_regwrite  = ifc_a.wb_regwrite;
  assign ifc_b.branch_taken = ifc_a.branch_taken;
  assign ifc_b.mem_req      = ifc_a.mem_req;
  assign ifc_b.mem_ready    = ifc_a.mem_ready;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}
  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {ifc_a.pc_en, ifc_a.ifid_en, ifc_a.ifid_flush, ifc_a.idex_en, ifc_a.idex_flush};
  assign ctl_b = {ifc_b.pc_en, ifc_b.ifid_en, ifc_b.ifid_flush, ifc_b.idex_en, ifc_b.idex_flush};

  localparam logic [4:0] C_DEF   = 5'b11010;
  localparam logic [4:0] C_STALL = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b00011;
  localparam logic [4:0] C_BR    = 5'b11111;
  localparam logic [4:0] C_FL    = 5'b11110;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifc_a.id_rs1 = 5'd0;       ifc_a.id_rs2 = 5'd0;
    ifc_a.id_use_rs1 = 1'b0;   ifc_a.id_use_rs2 = 1'b0;
    ifc_a.ex_rs1 = 5'd0;       ifc_a.ex_rs2 = 5'd0;
    ifc_a.ex_rd = 5'd0;        ifc_a.ex_memread = 1'b0;
    ifc_a.mem_rd = 5'd0;       ifc_a.wb_rd = 5'd0;
    ifc_a.mem_regwrite = 1'b0; ifc_a.wb_regwrite = 1'b0;
    ifc_a.branch_taken = 1'b0; ifc_a.mem_req = 1'b0;
    ifc_a.mem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loaduse(input logic [4:0] r);
    ifc_a.ex_memread = 1'b1; ifc_a.ex_rd = r;
    ifc_a.id_rs1 = r;        ifc_a.id_use_rs1 = 1'b1;
  endtask

  initial begin
    // Reset with active inputs: outputs must stay idle.
    idle();
    ifc_a.mem_req = 1'b1; ifc_a.mem_regwrite = 1'b1; ifc_a.mem_rd = 5'd3; ifc_a.ex_rs1 = 5'd3;
    #2;
    chk("rst_ctl", 32'(ctl_a), 32'(C_DEF));
    chk("rst_fwd", 32'({ifc_a.fwd_a, ifc_a.fwd_b}), 32'h0);
    chk("rst_state", 32'(ifc_a.state), 32'h0);
    chk("rst_stall", 32'(ifc_a.stall_cycles), 32'h0);
    chk("rst_tmo", 32'(ifc_a.mem_timeout), 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    cyc();

    // Load-use on rs1, then release.
    set_loaduse(5'd5);
    #2 chk("lu_ctl", 32'(ctl_a), 32'(C_LU));
    chk("lu_state", 32'(ifc_a.state), 32'h0);
    cyc();
    idle();
    #2 chk("lu_after_ctl", 32'(ctl_a), 32'(C_DEF));
    chk("lu_stall", 32'(ifc_a.stall_cycles), 32'd1);
    cyc();

    // rs2 match only counts when ID actually reads rs2.
    ifc_a.ex_memread = 1'b1; ifc_a.ex_rd = 5'd9; ifc_a.id_rs2 = 5'd9; ifc_a.id_rs1 = 5'd2;
    #2 chk("lu_rs2_unused", 32'(ctl_a), 32'(C_DEF));
    ifc_a.id_use_rs2 = 1'b1;
    #2 chk("lu_rs2_used", 32'(ctl_a), 32'(C_LU));
    cyc();
    idle();

    // x0 never stalls or forwards.
    set_loaduse(5'd0);
    ifc_a.mem_regwrite = 1'b1; ifc_a.wb_regwrite = 1'b1;
    #2 chk("x0_ctl", 32'(ctl_a), 32'(C_DEF));
    chk("x0_fwd_a", 32'(ifc_a.fwd_a), 32'h0);
    cyc();
    idle();

    // Forwarding priority.
    ifc_a.mem_rd = 5'd7; ifc_a.wb_rd = 5'd7; ifc_a.ex_rs2 = 5'd7; ifc_a.ex_rs1 = 5'd4;
    ifc_a.mem_regwrite = 1'b1; ifc_a.wb_regwrite = 1'b1;
    #2 chk("fwd_mem_wins", 32'({ifc_a.fwd_a, ifc_a.fwd_b}), 32'b0010);
    ifc_a.mem_regwrite = 1'b0;
    #2 chk("fwd_wb", 32'({ifc_a.fwd_a, ifc_a.fwd_b}), 32'b0001);
    ifc_a.ex_rs1 = 5'd7;
    #2 chk("fwd_a_wb", 32'({ifc_a.fwd_a, ifc_a.fwd_b}), 32'b0101);
    ifc_a.mem_regwrite = 1'b1; ifc_a.mem_rd = 5'd4; ifc_a.ex_rs1 = 5'd4;
    #2 chk("fwd_split", 32'({ifc_a.fwd_a, ifc_a.fwd_b}), 32'b1001);
    cyc();
    idle();

    // Taken branch together with load-use: branch wins, then FLUSH on dut_a.
    ifc_a.branch_taken = 1'b1;
    set_loaduse(5'd5);
    #2 chk("br0_ctl", 32'(ctl_a), 32'(C_BR));
    chk("br0_state", 32'(ifc_a.state), 32'h0);
    cyc();
    #2 chk("br1_ctl", 32'(ctl_a), 32'(C_FL));
    chk("br1_state", 32'(ifc_a.state), 32'h3);
    chk("br1_b_ctl", 32'(ctl_b), 32'(C_BR));
    chk("br1_b_state", 32'(ifc_b.state), 32'h0);
    cyc();
    #2 chk("br2_ctl", 32'(ctl_a), 32'(C_FL));
    chk("br2_state", 32'(ifc_a.state), 32'h3);
    cyc();
    idle();
    #2 chk("br3_ctl", 32'(ctl_a), 32'(C_DEF));
    chk("br3_state", 32'(ifc_a.state), 32'h0);
    chk("br3_stall", 32'(ifc_a.stall_cycles), 32'd2);
    cyc();

    // Memory wait: 4 stalled cycles; dut_b times out on the 4th.
    ifc_a.mem_req = 1'b1;
    #2 chk("mw1_ctl", 32'(ctl_a), 32'(C_STALL));
    chk("mw1_state", 32'(ifc_a.state), 32'h0);
    cyc();
    for (int i = 2; i <= 4; i++) begin
      #2 chk($sformatf("mw%0d_ctl", i), 32'(ctl_a), 32'(C_STALL));
      chk($sformatf("mw%0d_state", i), 32'(ifc_a.state), 32'h2);
      if (i == 4) chk("tmo_b_release", 32'(ctl_b), 32'(C_DEF));
      cyc();
    end
    chk("tmo_b_flag", 32'(ifc_b.mem_timeout), 32'h1);
    chk("tmo_b_state", 32'(ifc_b.state), 32'h0);
    chk("mw_stall", 32'(ifc_a.stall_cycles), 32'd6);
    ifc_a.mem_ready = 1'b1;
    set_loaduse(5'd6);
    #2 chk("mw_ready_ctl", 32'(ctl_a), 32'(C_LU));
    chk("mw_ready_state", 32'(ifc_a.state), 32'h2);
    cyc();
    idle();
    chk("mw_done_state", 32'(ifc_a.state), 32'h0);
    chk("mw_done_stall", 32'(ifc_a.stall_cycles), 32'd7);
    chk("mw_tmo_a", 32'(ifc_a.mem_timeout), 32'h0);
    chk("tmo_b_stall", 32'(ifc_b.stall_cycles), 32'd6);

    // Memory stall inside FLUSH holds the squash counter.
    ifc_a.branch_taken = 1'b1;
    cyc();
    idle();
    ifc_a.mem_req = 1'b1;
    #2 chk("flst_ctl", 32'(ctl_a), 32'(C_STALL));
    chk("flst_state", 32'(ifc_a.state), 32'h3);
    cyc();
    idle();
    #2 chk("flh1_ctl", 32'(ctl_a), 32'(C_FL));
    cyc();
    #2 chk("flh2_ctl", 32'(ctl_a), 32'(C_FL));
    chk("flh2_state", 32'(ifc_a.state), 32'h3);
    cyc();
    chk("flh_done", 32'(ifc_a.state), 32'h0);
    chk("tmo_b_sticky", 32'(ifc_b.mem_timeout), 32'h1);

    // Asynchronous reset mid FLUSH (a) / MEM_WAIT (b).
    ifc_a.branch_taken = 1'b1;
    cyc();
    idle();
    ifc_a.mem_req = 1'b1;
    cyc();
    chk("pre_rst_a", 32'(ifc_a.state), 32'h3);
    chk("pre_rst_b", 32'(ifc_b.state), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state_a", 32'(ifc_a.state), 32'h0);
    chk("arst_state_b", 32'(ifc_b.state), 32'h0);
    chk("arst_ctl_a", 32'(ctl_a), 32'(C_DEF));
    chk("arst_stall_a", 32'(ifc_a.stall_cycles), 32'h0);
    chk("arst_tmo_b", 32'(ifc_b.mem_timeout), 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ctl", 32'(ctl_a), 32'(C_DEF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives the enable and flush inputs of the PC, IF/ID and ID/EX pipeline registers, and the EX-stage operand forwarding selects. A small FSM handles load-use bubbles, taken-branch squashing (configurable penalty) and multi-cycle data-memory waits with timeout. It sits beside the ID/EX register and consumes register indices from ID, EX, MEM and WB.

Parameters:
BR_BUBBLES, 1, cycles of IF/ID squash after a taken branch (1..15)
MEM_TIMEOUT, 255, max MEM_WAIT cycles before the timeout error (1..65535)
CNT_W, 16, width of stall_cycles perf counter

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  5  source regs of instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  5  source regs of instruction in EX (ID/EX outputs)
ex_rd  in  5  dest reg in EX
ex_memread  in  1  EX instruction is a load
mem_rd, wb_rd  in  5  dest reg in MEM / WB
mem_regwrite, wb_regwrite  in  1  MEM / WB instruction writes rd
branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_req  in  1  MEM stage has an outstanding data access
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID capture enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX capture enable
idex_flush  out  1  ID/EX loads bubble (all control zero)
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
state  out  2  current FSM state (debug)
mem_timeout  out  1  sticky error: MEM_WAIT exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: RUN=00, MEM_WAIT=10, FLUSH=11 (01 unused; decodes as RUN).
- Reset (async, rst_n=0): state=RUN, flush counter=0, wait counter=0, mem_timeout=0, stall_cycles=0. Outputs during reset: pc_en=ifid_en=idex_en=1, flushes=0, fwd=00.
- Defaults: pc_en=ifid_en=idex_en=1, ifid_flush=idex_flush=0.
- memstall = mem_req & ~mem_ready. loaduse = ex_memread & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- RUN priority (highest first):
  - memstall: all enables 0, no flush. Next state MEM_WAIT, wait counter=1.
  - branch_taken: ifid_flush=1, idex_flush=1, pc_en=1. Next state FLUSH with counter=BR_BUBBLES-1 if BR_BUBBLES>1, else RUN.
  - loaduse: pc_en=0, ifid_en=0, idex_flush=1. This gives exactly one bubble. Stay in RUN.
- MEM_WAIT:
  - memstall: all enables 0, wait counter++.
  - Wait counter reaching MEM_TIMEOUT: set mem_timeout=1 and go to RUN. The pipeline releases that cycle.
  - mem_ready=1 (or mem_req=0): outputs and next state computed exactly as in RUN with memstall forced 0, same cycle.
- FLUSH:
  - memstall: all enables 0, counter holds.
  - Otherwise ifid_flush=1, pc_en=1, counter--. Go to RUN when counter reaches 0.
  - branch_taken and loaduse are ignored (EX holds a bubble).
- Forwarding (combinational, every state):
  - fwd_a=10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=00. fwd_b is identical on ex_rs2. MEM beats WB.
- Control outputs are combinational from state and inputs. state, counters and mem_timeout are registered.
- stall_cycles increments on each rising edge where pc_en=0, saturating at all-ones. It is cleared only by reset.
- mem_timeout is cleared only by reset.
- Register x0 never triggers a hazard or forward.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_memread=0) all defaults; stall_cycles=1.
- x0 immunity: ex_rd=0 load, id_rs1=0; mem_rd=0, ex_rs1=0 -> no stall, fwd_a=00.
- Forward priority: mem_rd=wb_rd=ex_rs2=7, both regwrite=1 -> fwd_b=10; drop mem_regwrite -> fwd_b=01.
- Branch with BR_BUBBLES=3 (branch_taken and loaduse asserted together) -> cycle0 both flushes, no stall; cycles1-2 ifid_flush only; cycle3 RUN.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> enables 0 for 4 cycles, state=MEM_WAIT, release on the ready cycle; stall_cycles=4. With MEM_TIMEOUT=3 and no ready -> mem_timeout=1 after 3 wait cycles, state=RUN.
- Reset mid-FLUSH/MEM_WAIT: drop rst_n asynchronously -> state=00 immediately, counters and mem_timeout 0, enables 1.
